rgu_seq_ctrl: RTL and testbench

- Parametrised reset sequencer: the next-generation RGU core.
- Drives NUM_CH active-low domain resets from power-good, watchdog and per-channel software requests.
- Releases channels in ascending index order with a programmable inter-stage gap.
- Records the last reset cause. Sits between the always-on clock/power logic and all SoC domain reset inputs.

---
 rtl/rgu_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_rgu_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgu_seq_ctrl.sv
// rtl/rgu_seq_ctrl.sv - staged domain reset sequencer with watchdog/soft reset handling.
// Optional RGU_DFT_BYPASS_EN adds a scan-mode override of rst_ch_n.
module rgu_seq_ctrl #(
  parameter int NUM_CH    = 8,
  parameter int NUM_WDT   = 4,
  parameter int STAGE_DLY = 16,
  parameter int WDT_HOLD  = 64,
  parameter int SW_PULSE  = 8
) (
  input  logic               clk,
  input  logic               sys_reset,
  input  logic               sys_pwrgd,
  input  logic [NUM_WDT-1:0] wdt_rst_n,
  input  logic [NUM_CH-1:0]  sw_rst_req,
`ifdef RGU_DFT_BYPASS_EN
  input  logic               dft_scan_mode,
  input  logic               dft_test_rstn,
`endif
  output logic [NUM_CH-1:0]  rst_ch_n,
  output logic               rst_done,
  output logic [1:0]         rst_cause,
  output logic [NUM_WDT-1:0] wdt_src
);

  localparam int MAX_A = (STAGE_DLY > WDT_HOLD) ? STAGE_DLY : WDT_HOLD;
  localparam int MAX_C = (MAX_A > SW_PULSE) ? MAX_A : SW_PULSE;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam int IW    = $clog2(NUM_CH) + 1;

  localparam logic [CW-1:0] STG_LAST = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_HOLD - 1);
  localparam logic [CW-1:0] SW_LEN   = CW'(SW_PULSE);
  localparam logic [IW-1:0] CH_LAST  = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, WDT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_CH-1:0]    ch_q, ch_d;
  logic                 done_q, done_d;
  logic [1:0]           cause_q, cause_d;
  logic [NUM_WDT-1:0]   src_q, src_d;
  logic [CW-1:0]        sw_cnt_q [NUM_CH];
  logic [CW-1:0]        sw_cnt_d [NUM_CH];
  logic                 wdt_any;

  assign wdt_any = ~&wdt_rst_n;

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      ch_q     <= '0;
      done_q   <= 1'b0;
      cause_q  <= 2'b00;
      src_q    <= '0;
      sw_cnt_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ch_q     <= ch_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
      src_q    <= src_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ch_d     = ch_q;
    done_d   = done_q;
    cause_d  = cause_q;
    src_d    = src_q;
    sw_cnt_d = sw_cnt_q;

    if (state_q == HOLD) begin
      ch_d = '0;
      if (sys_pwrgd) begin
        state_d = RELEASE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    end else if (!sys_pwrgd) begin
      state_d  = HOLD;
      ch_d     = '0;
      done_d   = 1'b0;
      cause_d  = 2'b01;
      sw_cnt_d = '{default: '0};
    end else if (state_q != WDT && wdt_any) begin
      state_d  = WDT;
      ch_d     = '0;
      done_d   = 1'b0;
      cnt_d    = '0;
      src_d    = ~wdt_rst_n;
      cause_d  = 2'b10;
      sw_cnt_d = '{default: '0};
    end else begin
      case (state_q)
        RELEASE: begin
          if (cnt_q == STG_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + IW'(1);
            for (int k = 0; k < NUM_CH; k++) begin
              if (idx_q == IW'(k)) ch_d[k] = 1'b1;
            end
            if (idx_q == CH_LAST) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          // A request reloads the full pulse length, so re-requests extend the pulse.
          for (int i = 0; i < NUM_CH; i++) begin
            if (sw_rst_req[i])
              sw_cnt_d[i] = SW_LEN;
            else if (sw_cnt_q[i] != '0)
              sw_cnt_d[i] = sw_cnt_q[i] - CW'(1);
            ch_d[i] = (sw_cnt_d[i] == '0);
          end
        end
        WDT: begin
          ch_d  = '0;
          src_d = src_q | ~wdt_rst_n;
          if (cnt_q != WDT_LAST) begin
            cnt_d = cnt_q + CW'(1);
          end else if (!wdt_any) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RGU_DFT_BYPASS_EN
  assign rst_ch_n = dft_scan_mode ? {NUM_CH{dft_test_rstn}} : ch_q;
`else
  assign rst_ch_n = ch_q;
`endif
  assign rst_done  = done_q;
  assign rst_cause = cause_q;
  assign wdt_src   = src_q;

endmodule

// File: tb/tb_rgu_seq_ctrl.sv
// tb/tb_rgu_seq_ctrl.sv - scoreboard bench for rgu_seq_ctrl (DFT test only with RGU_DFT_BYPASS_EN).
module tb_rgu_seq_ctrl;

  localparam int NUM_CH    = 4;
  localparam int NUM_WDT   = 2;
  localparam int STAGE_DLY = 4;
  localparam int WDT_HOLD  = 8;
  localparam int SW_PULSE  = 3;

  typedef struct {
    logic [3:0] ch;
    logic       done;
    logic [1:0] cause;
    logic [1:0] src;
  } exp_t;

  logic              clk = 1'b0;
  logic              sys_reset;
  logic              sys_pwrgd;
  logic [NUM_WDT-1:0] wdt_rst_n;
  logic [NUM_CH-1:0]  sw_rst_req;
  logic [NUM_CH-1:0]  rst_ch_n;
  logic               rst_done;
  logic [1:0]         rst_cause;
  logic [NUM_WDT-1:0] wdt_src;
`ifdef RGU_DFT_BYPASS_EN
  logic               dft_scan_mode;
  logic               dft_test_rstn;
`endif

  exp_t sb[$];
  exp_t x, got;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  rgu_seq_ctrl #(
    .NUM_CH(NUM_CH), .NUM_WDT(NUM_WDT), .STAGE_DLY(STAGE_DLY),
    .WDT_HOLD(WDT_HOLD), .SW_PULSE(SW_PULSE)
  ) dut (
    .clk(clk),
    .sys_reset(sys_reset),
    .sys_pwrgd(sys_pwrgd),
    .wdt_rst_n(wdt_rst_n),
    .sw_rst_req(sw_rst_req),
`ifdef RGU_DFT_BYPASS_EN
    .dft_scan_mode(dft_scan_mode),
    .dft_test_rstn(dft_test_rstn),
`endif
    .rst_ch_n(rst_ch_n),
    .rst_done(rst_done),
    .rst_cause(rst_cause),
    .wdt_src(wdt_src)
  );

  // Channels released n edges after the RELEASE-entry edge e0.
  function automatic logic [3:0] rel(int n, int e0);
    logic [3:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k] = ((n - e0) >= STAGE_DLY * (k + 1));
    return r;
  endfunction

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      sys_reset = 1'b1; sys_pwrgd = 1'b1; wdt_rst_n = 2'b11; sw_rst_req = 4'b0000;
      x.ch = 4'b0000; x.done = 1'b0; x.cause = 2'b00; x.src = 2'b00;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL reset n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
  endtask

  task automatic test_por();
    for (int n = 0; n <= 18; n++) begin
      sys_reset = 1'b0; sys_pwrgd = 1'b1; wdt_rst_n = 2'b11; sw_rst_req = 4'b0000;
      x.ch = rel(n, 0); x.done = (n >= 16); x.cause = 2'b00; x.src = 2'b00;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL por n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
  endtask

  task automatic test_soft();
    // Re-request on channel 2 two cycles in: five low cycles in total.
    for (int n = 0; n <= 7; n++) begin
      sw_rst_req = (n == 0 || n == 2) ? 4'b0100 : 4'b0000;
      x.ch = (n <= 4) ? 4'b1011 : 4'b1111; x.done = 1'b1; x.cause = 2'b00; x.src = 2'b00;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL soft_retrig n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
    for (int n = 0; n <= 4; n++) begin
      sw_rst_req = (n == 0) ? 4'b1001 : (n == 1) ? 4'b0010 : 4'b0000;
      x.ch = 4'b1111;
      if (n <= 2) x.ch = x.ch & 4'b0110;
      if (n >= 1 && n <= 3) x.ch = x.ch & 4'b1101;
      x.done = 1'b1; x.cause = 2'b00; x.src = 2'b00;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL soft_multi n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
  endtask

  task automatic test_wdt();
    for (int n = 0; n <= 28; n++) begin
      sw_rst_req = 4'b0000;
      wdt_rst_n  = (n < 12) ? 2'b10 : 2'b11;
      x.ch = (n < 12) ? 4'b0000 : rel(n, 12); x.done = (n >= 28); x.cause = 2'b10; x.src = 2'b01;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL wdt n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
  endtask

  task automatic test_wdt_hold();
    // Short pulse: hold lasts WDT_HOLD cycles; a later bit is ORed into wdt_src.
    for (int n = 0; n <= 24; n++) begin
      wdt_rst_n = (n == 0) ? 2'b01 : (n == 3) ? 2'b10 : 2'b11;
      x.ch = (n < 8) ? 4'b0000 : rel(n, 8); x.done = (n >= 24); x.cause = 2'b10;
      x.src = (n < 3) ? 2'b10 : 2'b11;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL wdt_hold n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
  endtask

  task automatic test_pg_loss();
    for (int n = 0; n <= 27; n++) begin
      wdt_rst_n = 2'b11; sw_rst_req = 4'b0000;
      sys_pwrgd = (n == 0 || n == 10) ? 1'b0 : 1'b1;
      if (n == 0 || n == 10) x.ch = 4'b0000;
      else if (n < 10)       x.ch = rel(n, 1);
      else                   x.ch = rel(n, 11);
      x.done = (n >= 27); x.cause = 2'b01; x.src = 2'b11;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL pg_loss n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
  endtask

  task automatic test_priority();
    // sw_rst_req is also driven during HOLD and RELEASE, where it must be ignored.
    for (int n = 0; n <= 18; n++) begin
      sys_pwrgd  = (n <= 1) ? 1'b0 : 1'b1;
      wdt_rst_n  = (n <= 1) ? 2'b00 : 2'b11;
      sw_rst_req = (n <= 1 || (n >= 5 && n <= 8)) ? 4'b1111 : 4'b0000;
      x.ch = (n <= 1) ? 4'b0000 : rel(n, 2); x.done = (n >= 18); x.cause = 2'b01; x.src = 2'b11;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL priority n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
    sw_rst_req = 4'b0000;
  endtask

  task automatic test_sysreset_mid();
    for (int n = 0; n <= 10; n++) begin
      sys_reset = (n == 6);
      sys_pwrgd = (n == 0) ? 1'b0 : 1'b1;
      if (n == 0 || n == 6) x.ch = 4'b0000;
      else if (n < 6)       x.ch = rel(n, 1);
      else                  x.ch = rel(n, 7);
      x.done = 1'b0; x.cause = (n < 6) ? 2'b01 : 2'b00; x.src = (n < 6) ? 2'b11 : 2'b00;
      sb.push_back(x);
      @(posedge clk); #1;
      got = sb.pop_front(); tests_run++;
      if ({rst_ch_n, rst_done, rst_cause, wdt_src} !== {got.ch, got.done, got.cause, got.src}) begin
        tests_failed++;
        $display("FAIL sysreset_mid n=%0d got ch=%b done=%b cause=%b src=%b want ch=%b done=%b cause=%b src=%b",
                 n, rst_ch_n, rst_done, rst_cause, wdt_src, got.ch, got.done, got.cause, got.src);
      end
    end
    sys_reset = 1'b0;
  endtask

`ifdef RGU_DFT_BYPASS_EN
  task automatic test_dft();
    sys_reset = 1'b1; sys_pwrgd = 1'b0;
    @(posedge clk); #1;
    sys_reset = 1'b0;
    @(posedge clk); #1;
    dft_test_rstn = 1'b0; dft_scan_mode = 1'b1; #1;
    tests_run++;
    if ({rst_ch_n, rst_done} !== {4'b0000, 1'b0}) begin
      tests_failed++;
      $display("FAIL dft_low got ch=%b done=%b want ch=0000 done=0", rst_ch_n, rst_done);
    end
    dft_test_rstn = 1'b1; #1;
    tests_run++;
    if ({rst_ch_n, rst_done} !== {4'b1111, 1'b0}) begin
      tests_failed++;
      $display("FAIL dft_high got ch=%b done=%b want ch=1111 done=0", rst_ch_n, rst_done);
    end
    dft_scan_mode = 1'b0; #1;
    tests_run++;
    if (rst_ch_n !== 4'b0000) begin
      tests_failed++;
      $display("FAIL dft_off got ch=%b want ch=0000", rst_ch_n);
    end
  endtask
`endif

  initial begin
    sys_reset = 1'b1; sys_pwrgd = 1'b1; wdt_rst_n = 2'b11; sw_rst_req = 4'b0000;
`ifdef RGU_DFT_BYPASS_EN
    dft_scan_mode = 1'b0; dft_test_rstn = 1'b0;
`endif
    test_reset();
    test_por();
    test_soft();
    test_wdt();
    test_wdt_hold();
    test_pg_loss();
    test_priority();
    test_sysreset_mid();
`ifdef RGU_DFT_BYPASS_EN
    test_dft();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
